// File: rtl/hash_table_pkg.sv
// Shared hash-table pipeline types: request commands, head-table entry layout
// and the head-pointer table's clear-FSM states.
package hash_table;

    localparam int HT_CMD_WIDTH      = 2;
    localparam int HT_HEAD_PTR_WIDTH = 10;

    typedef enum logic [HT_CMD_WIDTH-1:0] {
        HT_CMD_SEARCH = 2'd0,
        HT_CMD_INSERT = 2'd1,
        HT_CMD_DELETE = 2'd2
    } ht_command_t;

    typedef struct packed {
        logic [HT_HEAD_PTR_WIDTH-1:0] head_ptr;
        logic                         head_ptr_val;
    } head_entry_t;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/simple_dual_port_ram_single_clock.sv
// One-write/one-read RAM on a single clock; read data appears the cycle after
// the address and returns the old contents on a same-address write.
module simple_dual_port_ram_single_clock #(
    parameter int DATA_WIDTH = 11,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/head_ptr_table.sv
// Bucket head-pointer lookup stage feeding the data table, with update bypass and bulk clear.
// Define HEAD_PTR_TABLE_CLEAR_ON_RESET_EN to start a full clear automatically when reset releases.
module head_ptr_table
    import hash_table::*;
#(
    parameter int KEY_WIDTH      = 32,
    parameter int VALUE_WIDTH    = 16,
    parameter int BUCKET_WIDTH   = 8,
    parameter int HEAD_PTR_WIDTH = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [KEY_WIDTH-1:0]      in_key,
    input  logic [VALUE_WIDTH-1:0]    in_value,
    input  logic [BUCKET_WIDTH-1:0]   in_bucket,
    input  logic [HT_CMD_WIDTH-1:0]   in_cmd,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [KEY_WIDTH-1:0]      out_key,
    output logic [VALUE_WIDTH-1:0]    out_value,
    output logic [BUCKET_WIDTH-1:0]   out_bucket,
    output logic [HT_CMD_WIDTH-1:0]   out_cmd,
    output logic [HEAD_PTR_WIDTH-1:0] out_head_ptr,
    output logic                      out_head_ptr_val,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic                      upd_en,
    input  logic [BUCKET_WIDTH-1:0]   upd_bucket,
    input  logic [HEAD_PTR_WIDTH-1:0] upd_head_ptr,
    input  logic                      upd_head_ptr_val,
    input  logic                      clear_ram_run_i,
    output logic                      clear_ram_done_o
);
    localparam int                      ENTRY_W   = HEAD_PTR_WIDTH + 1;
    localparam logic [BUCKET_WIDTH-1:0] LAST_ADDR = '1;

    clr_state_t                state_q, state_d;
    logic [BUCKET_WIDTH-1:0]   clr_addr_q, clr_addr_d;
    logic                      clear_flag;
    logic                      upd_act;

    logic                      ram_we;
    logic [BUCKET_WIDTH-1:0]   ram_waddr;
    logic [ENTRY_W-1:0]        ram_wdata, ram_rdata;

    logic                      accept;
    logic                      out_valid_q, out_valid_d;
    logic                      fresh_q;
    logic                      byp_q;
    logic [ENTRY_W-1:0]        byp_entry_q, hold_q, hold_d, cur_entry, upd_entry;
    logic [KEY_WIDTH-1:0]      key_q;
    logic [VALUE_WIDTH-1:0]    value_q;
    logic [BUCKET_WIDTH-1:0]   bucket_q;
    logic [HT_CMD_WIDTH-1:0]   cmd_q;

    assign upd_entry = {upd_head_ptr, upd_head_ptr_val};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
`ifdef HEAD_PTR_TABLE_CLEAR_ON_RESET_EN
            state_q    <= CLR_CLEAR;
`else
            state_q    <= CLR_IDLE;
`endif
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // A run pulse always restarts from address 0, even mid-clear.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (clear_ram_run_i) begin
            state_d    = CLR_CLEAR;
            clr_addr_d = '0;
        end else if (state_q == CLR_CLEAR) begin
            if (clr_addr_q == LAST_ADDR) begin
                state_d = CLR_IDLE;
            end else begin
                clr_addr_d = clr_addr_q + BUCKET_WIDTH'(1);
            end
        end
    end

    always_comb begin
        clear_flag       = (state_q == CLR_CLEAR);
        clear_ram_done_o = !rst_i && clear_flag && (clr_addr_q == LAST_ADDR) && !clear_ram_run_i;
        upd_act          = upd_en && !clear_flag;
        ram_we           = upd_act;
        ram_waddr        = upd_bucket;
        ram_wdata        = upd_entry;
        if (clear_flag) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr_q;
            ram_wdata = '0;
        end
    end

    simple_dual_port_ram_single_clock #(
        .DATA_WIDTH (ENTRY_W),
        .ADDR_WIDTH (BUCKET_WIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (in_bucket),
        .rdata_o (ram_rdata)
    );

    assign accept    = in_valid && in_ready;
    assign in_ready  = !clear_flag && (!out_valid_q || out_ready);
    // First output cycle takes RAM data (or a same-cycle update); afterwards the held copy.
    assign cur_entry = !fresh_q ? hold_q : (byp_q ? byp_entry_q : ram_rdata);

    always_comb begin
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        hold_d = cur_entry;
        if (out_valid_q && !out_ready && upd_act && (upd_bucket == bucket_q)) begin
            hold_d = upd_entry;
        end
    end

    // Output stage: valid/fresh under reset, payload registers free-running
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            fresh_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            fresh_q     <= accept;
        end
    end

    always_ff @(posedge clk_i) begin
        hold_q      <= hold_d;
        byp_q       <= upd_act && (upd_bucket == in_bucket);
        byp_entry_q <= upd_entry;
        if (accept) begin
            key_q    <= in_key;
            value_q  <= in_value;
            bucket_q <= in_bucket;
            cmd_q    <= in_cmd;
        end
    end

    assign out_valid        = out_valid_q;
    assign out_key          = key_q;
    assign out_value        = value_q;
    assign out_bucket       = bucket_q;
    assign out_cmd          = cmd_q;
    assign out_head_ptr     = cur_entry[ENTRY_W-1:1];
    assign out_head_ptr_val = cur_entry[0];

endmodule

// File: tb/tb_head_ptr_table.sv
// Scoreboard bench for head_ptr_table: clear, update/lookup, bypass, stall and reset-mid-clear.
module tb_head_ptr_table;
    import hash_table::*;

    localparam int KW = 32;
    localparam int VW = 16;
    localparam int BW = 8;
    localparam int PW = 10;

    typedef struct packed {
        logic [KW-1:0]           key;
        logic [VW-1:0]           value;
        logic [BW-1:0]           bucket;
        logic [HT_CMD_WIDTH-1:0] cmd;
        logic [PW-1:0]           ptr;
        logic                    val;
    } txn_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [KW-1:0]           in_key;
    logic [VW-1:0]           in_value;
    logic [BW-1:0]           in_bucket;
    logic [HT_CMD_WIDTH-1:0] in_cmd;
    logic                    in_valid;
    logic                    in_ready;
    logic [KW-1:0]           out_key;
    logic [VW-1:0]           out_value;
    logic [BW-1:0]           out_bucket;
    logic [HT_CMD_WIDTH-1:0] out_cmd;
    logic [PW-1:0]           out_head_ptr;
    logic                    out_head_ptr_val;
    logic                    out_valid;
    logic                    out_ready;
    logic                    upd_en;
    logic [BW-1:0]           upd_bucket;
    logic [PW-1:0]           upd_head_ptr;
    logic                    upd_head_ptr_val;
    logic                    clear_ram_run;
    logic                    clear_ram_done;

    txn_t        exp_q[$];
    txn_t        obs_q[$];
    txn_t        pend;
    bit          pend_v;
    logic [PW-1:0] model_ptr [256];
    logic          model_val [256];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    head_ptr_table #(
        .KEY_WIDTH      (KW),
        .VALUE_WIDTH    (VW),
        .BUCKET_WIDTH   (BW),
        .HEAD_PTR_WIDTH (PW)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .in_key           (in_key),
        .in_value         (in_value),
        .in_bucket        (in_bucket),
        .in_cmd           (in_cmd),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .out_key          (out_key),
        .out_value        (out_value),
        .out_bucket       (out_bucket),
        .out_cmd          (out_cmd),
        .out_head_ptr     (out_head_ptr),
        .out_head_ptr_val (out_head_ptr_val),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .upd_en           (upd_en),
        .upd_bucket       (upd_bucket),
        .upd_head_ptr     (upd_head_ptr),
        .upd_head_ptr_val (upd_head_ptr_val),
        .clear_ram_run_i  (clear_ram_run),
        .clear_ram_done_o (clear_ram_done)
    );

    // Record handshaken outputs, advance the reference model, then step one clock.
    task automatic tick();
        txn_t o;
        #1;
        if (out_valid && out_ready) begin
            o = '{key: out_key, value: out_value, bucket: out_bucket, cmd: out_cmd,
                  ptr: out_head_ptr, val: out_head_ptr_val};
            obs_q.push_back(o);
        end
        if (rst) begin
            pend_v = 0;
        end else begin
            if (pend_v && out_ready) begin
                exp_q.push_back(pend);
                pend_v = 0;
            end else if (pend_v && upd_en && upd_bucket == pend.bucket) begin
                pend.ptr = upd_head_ptr;
                pend.val = upd_head_ptr_val;
            end
            if (in_valid && in_ready) begin
                pend.key    = in_key;
                pend.value  = in_value;
                pend.bucket = in_bucket;
                pend.cmd    = in_cmd;
                pend.ptr    = (upd_en && upd_bucket == in_bucket) ? upd_head_ptr : model_ptr[in_bucket];
                pend.val    = (upd_en && upd_bucket == in_bucket) ? upd_head_ptr_val : model_val[in_bucket];
                pend_v      = 1;
            end
            if (upd_en) begin
                model_ptr[upd_bucket] = upd_head_ptr;
                model_val[upd_bucket] = upd_head_ptr_val;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [BW-1:0] b);
        in_valid  = 1'b1;
        in_bucket = b;
        in_key    = $urandom;
        in_value  = VW'($urandom);
        in_cmd    = HT_CMD_SEARCH;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_key = '0; in_value = '0; in_bucket = '0;
        in_cmd = HT_CMD_SEARCH; out_ready = 1'b1; upd_en = 1'b0; upd_bucket = '0;
        upd_head_ptr = '0; upd_head_ptr_val = 1'b0; clear_ram_run = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (clear_ram_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", clear_ram_done); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_reset: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_clear();
        int cyc, ready_bad;
        bit done_seen;
        txn_t e, o;
        clear_ram_run = 1'b1;
        tick();
        clear_ram_run = 1'b0;
        set_req(8'h12);
        cyc = 1; ready_bad = 0; done_seen = 0;
        while (cyc < 400) begin
            if (clear_ram_done === 1'b1) begin done_seen = 1; break; end
            if (in_ready !== 1'b0) ready_bad++;
            tick();
            cyc++;
        end
        n_checks++;
        if (!done_seen || cyc != 256) begin
            n_fail++; $display("FAIL clear_latency: done_seen=%0d at cycle %0d expected cycle 256", done_seen, cyc);
        end
        n_checks++;
        if (ready_bad != 0) begin n_fail++; $display("FAIL clear_in_ready: high in %0d clear cycles expected 0", ready_bad); end
        for (int b = 0; b < 256; b++) begin model_ptr[b] = '0; model_val[b] = 1'b0; end
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || clear_ram_done !== 1'b0) begin
            n_fail++; $display("FAIL clear_exit: in_ready=%b done=%b expected 1/0", in_ready, clear_ram_done);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_head_ptr_val !== 1'b0 || out_bucket !== 8'h12) begin
            n_fail++; $display("FAIL clear_search: valid=%b val=%b bucket=%h expected 1/0/12", out_valid, out_head_ptr_val, out_bucket);
        end
        repeat (2) tick();
        n_checks++;
        if (exp_q.size() != 1 || obs_q.size() != 1) begin
            n_fail++; $display("FAIL clear_sb_count: got %0d outputs, expected %0d (1)", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL clear_sb: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_update_search();
        txn_t e, o;
        upd_en = 1'b1; upd_bucket = 8'h12; upd_head_ptr = 10'h05A; upd_head_ptr_val = 1'b1;
        tick();
        upd_en = 1'b0;
        set_req(8'h12);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_head_ptr !== 10'h05A || out_head_ptr_val !== 1'b1) begin
            n_fail++; $display("FAIL upd_search: valid=%b ptr=%h val=%b expected 1/05a/1", out_valid, out_head_ptr, out_head_ptr_val);
        end
        repeat (2) tick();
        n_checks++;
        if (exp_q.size() != 1 || obs_q.size() != 1) begin
            n_fail++; $display("FAIL upd_sb_count: got %0d outputs, expected %0d (1)", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL upd_sb: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_bypass();
        txn_t e, o;
        upd_en = 1'b1; upd_bucket = 8'h34; upd_head_ptr = 10'h100; upd_head_ptr_val = 1'b1;
        set_req(8'h34);
        tick();
        upd_en = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_head_ptr !== 10'h100 || out_head_ptr_val !== 1'b1) begin
            n_fail++; $display("FAIL bypass: valid=%b ptr=%h val=%b expected 1/100/1", out_valid, out_head_ptr, out_head_ptr_val);
        end
        repeat (2) tick();
        n_checks++;
        if (exp_q.size() != 1 || obs_q.size() != 1) begin
            n_fail++; $display("FAIL bypass_sb_count: got %0d outputs, expected %0d (1)", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL bypass_sb: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_stall();
        txn_t e, o;
        out_ready = 1'b0;
        set_req(8'h34);
        tick();
        set_req(8'h56);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_bucket !== 8'h34) begin
                n_fail++; $display("FAIL stall_hold[%0d]: valid=%b in_ready=%b bucket=%h expected 1/0/34", i, out_valid, in_ready, out_bucket);
            end
            n_checks++;
            if (out_head_ptr !== 10'h100 || out_head_ptr_val !== (i < 2 ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL stall_entry[%0d]: ptr=%h val=%b expected 100/%0d", i, out_head_ptr, out_head_ptr_val, i < 2);
            end
            if (i == 1) begin
                upd_en = 1'b1; upd_bucket = 8'h34; upd_head_ptr = 10'h100; upd_head_ptr_val = 1'b0;
            end
            tick();
            upd_en = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_bucket !== 8'h56) begin
            n_fail++; $display("FAIL stall_release: valid=%b bucket=%h expected 1/56", out_valid, out_bucket);
        end
        repeat (2) tick();
        n_checks++;
        if (exp_q.size() != 2 || obs_q.size() != 2) begin
            n_fail++; $display("FAIL stall_sb_count: got %0d outputs, expected %0d (2)", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL stall_sb: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        txn_t e, o;
        out_ready = 1'b1;
        for (int b = 1; b <= 3; b++) begin
            set_req(BW'(b));
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_bucket !== BW'(b)) begin
                n_fail++; $display("FAIL b2b[%0d]: valid=%b bucket=%h expected 1/%h", b, out_valid, out_bucket, BW'(b));
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: valid=%b expected 0", out_valid); end
        n_checks++;
        if (exp_q.size() != 3 || obs_q.size() != 3) begin
            n_fail++; $display("FAIL b2b_sb_count: got %0d outputs, expected %0d (3)", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL b2b_sb: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_clear_reset();
        int ready_bad, done_bad;
        txn_t e, o;
        set_req(8'h12);
        clear_ram_run = 1'b1;
        tick();
        clear_ram_run = 1'b0;
        set_req(8'h77);
        n_checks++;
        if (out_valid !== 1'b1 || out_head_ptr !== 10'h05A || out_head_ptr_val !== 1'b1) begin
            n_fail++; $display("FAIL clr_pre_data: valid=%b ptr=%h val=%b expected 1/05a/1", out_valid, out_head_ptr, out_head_ptr_val);
        end
        ready_bad = 0; done_bad = 0;
        for (int cyc = 1; cyc < 100; cyc++) begin
            if (in_ready !== 1'b0) ready_bad++;
            if (clear_ram_done !== 1'b0) done_bad++;
            tick();
        end
        n_checks++;
        if (ready_bad != 0) begin n_fail++; $display("FAIL clr_in_ready: high in %0d cycles expected 0", ready_bad); end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (clear_ram_done !== 1'b0) done_bad++;
            if (in_ready !== 1'b1) ready_bad++;
            tick();
        end
        n_checks++;
        if (done_bad != 0) begin n_fail++; $display("FAIL clr_abort_done: %0d done pulses expected 0", done_bad); end
        n_checks++;
        if (ready_bad != 0) begin n_fail++; $display("FAIL clr_abort_idle: in_ready low in %0d cycles expected 0", ready_bad); end
        n_checks++;
        if (exp_q.size() != 1 || obs_q.size() != 1) begin
            n_fail++; $display("FAIL clr_sb_count: got %0d outputs, expected %0d (1)", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL clr_sb: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        pend_v = 0;
        test_reset();
        test_clear();
        test_update_search();
        test_bypass();
        test_stall();
        test_back_to_back();
        test_clear_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/head_ptr_table.md
Name: head_ptr_table

Overview:
- Pipeline stage directly upstream of the data table.
- Accepts a hashed request (key, value, bucket, command) and reads the bucket's head pointer from a per-bucket RAM.
- Forwards the request with head_ptr / head_ptr_val downstream.
- Takes head-pointer updates back from the data table and clears all buckets on request.

Parameters:
- KEY_WIDTH, 32, key width
- VALUE_WIDTH, 16, value width
- BUCKET_WIDTH, 8, bucket index width; table depth = 2**BUCKET_WIDTH
- HEAD_PTR_WIDTH, 10, data-table address width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- in_key  in  KEY_WIDTH  request key
- in_value  in  VALUE_WIDTH  request value
- in_bucket  in  BUCKET_WIDTH  hashed bucket index
- in_cmd  in  HT_CMD_WIDTH  command (search/insert/delete), from package
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- out_key / out_value / out_bucket / out_cmd  out  as input widths  forwarded request
- out_head_ptr  out  HEAD_PTR_WIDTH  bucket head pointer
- out_head_ptr_val  out  1  bucket has a chain
- out_valid  out  1  output valid
- out_ready  in  1  downstream ready
- upd_en  in  1  head-pointer write strobe from the data table
- upd_bucket  in  BUCKET_WIDTH  bucket to update
- upd_head_ptr  in  HEAD_PTR_WIDTH  new head pointer
- upd_head_ptr_val  in  1  new valid flag (0 = bucket emptied)
- clear_ram_run_i  in  1  pulse: start clearing all buckets
- clear_ram_done_o  out  1  one-cycle pulse on the final clear write

Behaviour:
- Reset: out_valid=0, clear_ram_done_o=0, clear flag=0, clear address=0. in_ready follows its equation below. RAM contents are not reset unless CLEAR_ON_RESET_EN is defined.
- RAM: simple dual-port, one read port and one write port, 1-cycle read latency, unregistered output. Entry = {head_ptr, head_ptr_val}.
- in_ready = !clear_flag && (!out_valid || out_ready).
- Accept in cycle N: RAM read issued at in_bucket; request fields registered.
- Cycle N+1: out_valid=1; out_head_ptr/val come from RAM.
- The RAM read result is captured into the output register in cycle N+1, so a stalled output (out_valid && !out_ready) holds stable.
- out_valid drops after handshake unless a new request was accepted in the same cycle (full throughput, 1 req/cycle).
- Write-through bypass, with upd_en taking precedence over stale RAM data:
  - upd_en in cycle N with upd_bucket == accepted in_bucket: output shows the upd values in N+1.
  - upd_en while output held valid with upd_bucket == out_bucket: output register takes the upd values in the next cycle.
- upd_en writes RAM the same cycle. upd_en during clear is ignored.
- Clear FSM, states IDLE / CLEAR:
  - clear_ram_run_i moves to CLEAR and sets address=0.
  - CLEAR writes {0,0} to the address each cycle, then increments it.
  - At address == all-ones: clear_ram_done_o=1 and return to IDLE.
  - clear_ram_run_i during CLEAR restarts at address 0.
  - An output already valid at clear start is still delivered (data may be pre-clear).
  - in_ready=0 throughout CLEAR.
  - Clear of 2**BUCKET_WIDTH entries takes exactly 2**BUCKET_WIDTH cycles.
- Reset mid-clear: aborts; FSM returns to IDLE, no done pulse.

Optional Feature:
- Macro HEAD_PTR_TABLE_CLEAR_ON_RESET_EN.
- Defined: after rst_i deasserts, the FSM enters CLEAR automatically. in_ready stays 0 until clear_ram_done_o pulses, 2**BUCKET_WIDTH cycles later.
- Undefined: after reset the FSM is IDLE, and RAM contents stay undefined until clear_ram_run_i is pulsed.

Decomposition:
- Package hash_table: ht_command_t and HT_CMD_WIDTH, head-table entry struct, clear-FSM state enum.
- Sub-module: simple_dual_port_ram_single_clock (parameter DATA_WIDTH, ADDR_WIDTH). Bypass, output register and clear FSM stay in head_ptr_table.

Test Plan:
- Pulse clear_ram_run_i with BUCKET_WIDTH=8 -> done after 256 cycles; search bucket 0x12 -> out_head_ptr_val=0.
- upd_en bucket 0x12, ptr 0x05A, val 1; next cycle search 0x12 -> out_head_ptr=0x05A, val=1 at latency 1.
- Same-cycle upd_en bucket 0x34, ptr 0x100, and accepted search 0x34 -> output shows 0x100/1 (bypass).
- out_ready=0 for 5 cycles with output 0x34 valid; upd bucket 0x34 val=0 -> held output switches to val=0; in_ready=0 during stall; no request lost.
- Back-to-back searches of buckets 1,2,3 with out_ready=1 -> three consecutive out_valid cycles, fields in order.
- clear_ram_run_i while in_valid=1 -> in_ready=0 for 256 cycles; reset at clear cycle 100 -> no done pulse, FSM IDLE.
